// File: rtl/rgb_pwm.sv
// Three-channel active-low PWM stage with per-channel capture and period-aligned shadow load.
// Optional gamma shaping of the loaded duty is enabled by defining RGB_PWM_GAMMA_EN.
module rgb_pwm #(
    parameter int PWM_INTERVAL = 1200,
    parameter int DUTY_W       = $clog2(PWM_INTERVAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] pwm_value,
    input  logic [1:0]        state,
    output logic              red_n,
    output logic              green_n,
    output logic              blue_n,
    output logic              period_start
);

    localparam int CAP_W = $clog2(PWM_INTERVAL + 1);
    localparam int SQ_W  = 2 * CAP_W;
    localparam logic [CAP_W-1:0] MAX_DUTY = CAP_W'(PWM_INTERVAL);
    localparam logic [CAP_W-1:0] LAST_CNT = CAP_W'(PWM_INTERVAL - 1);

    typedef enum logic [1:0] {
        CH_RED   = 2'd0,
        CH_GREEN = 2'd1,
        CH_BLUE  = 2'd2,
        CH_NONE  = 2'd3
    } chan_e;

    chan_e chanSel;
    assign chanSel = chan_e'(state);

    logic [CAP_W-1:0] cnt_q, cnt_d;
    logic [CAP_W-1:0] capRed_q, capRed_d, capGreen_q, capGreen_d, capBlue_q, capBlue_d;
    logic [CAP_W-1:0] actRed_q, actRed_d, actGreen_q, actGreen_d, actBlue_q, actBlue_d;
    logic             redN_q, redN_d, greenN_q, greenN_d, blueN_q, blueN_d;
    logic             periodStart_q, periodStart_d;
    logic [CAP_W-1:0] dutyClamped;

    // Maps a captured duty to the on-time used for the next period.
    function automatic logic [CAP_W-1:0] shapeDuty(input logic [CAP_W-1:0] c);
`ifdef RGB_PWM_GAMMA_EN
        logic [SQ_W-1:0] sq;
        sq = SQ_W'(c) * SQ_W'(c);
        return CAP_W'(sq / SQ_W'(PWM_INTERVAL));
`else
        return c;
`endif
    endfunction

    always_comb begin
        if (32'(pwm_value) > 32'(PWM_INTERVAL)) begin
            dutyClamped = MAX_DUTY;
        end else begin
            dutyClamped = CAP_W'(pwm_value);
        end
    end

    // Act registers only change on the last count, so a pulse in flight is never altered.
    always_comb begin
        cnt_d         = (cnt_q == LAST_CNT) ? '0 : cnt_q + CAP_W'(1);
        capRed_d      = capRed_q;
        capGreen_d    = capGreen_q;
        capBlue_d     = capBlue_q;
        actRed_d      = actRed_q;
        actGreen_d    = actGreen_q;
        actBlue_d     = actBlue_q;
        case (chanSel)
            CH_RED:   capRed_d   = dutyClamped;
            CH_GREEN: capGreen_d = dutyClamped;
            CH_BLUE:  capBlue_d  = dutyClamped;
            default:  ;
        endcase
        if (cnt_q == LAST_CNT) begin
            actRed_d   = shapeDuty(capRed_q);
            actGreen_d = shapeDuty(capGreen_q);
            actBlue_d  = shapeDuty(capBlue_q);
        end
        redN_d        = !(cnt_q < actRed_q);
        greenN_d      = !(cnt_q < actGreen_q);
        blueN_d       = !(cnt_q < actBlue_q);
        periodStart_d = (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            capRed_q      <= '0;
            capGreen_q    <= '0;
            capBlue_q     <= '0;
            actRed_q      <= '0;
            actGreen_q    <= '0;
            actBlue_q     <= '0;
            redN_q        <= 1'b1;
            greenN_q      <= 1'b1;
            blueN_q       <= 1'b1;
            periodStart_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            capRed_q      <= capRed_d;
            capGreen_q    <= capGreen_d;
            capBlue_q     <= capBlue_d;
            actRed_q      <= actRed_d;
            actGreen_q    <= actGreen_d;
            actBlue_q     <= actBlue_d;
            redN_q        <= redN_d;
            greenN_q      <= greenN_d;
            blueN_q       <= blueN_d;
            periodStart_q <= periodStart_d;
        end
    end

    assign red_n        = redN_q;
    assign green_n      = greenN_q;
    assign blue_n       = blueN_q;
    assign period_start = periodStart_q;

endmodule

// File: tb/tb_rgb_pwm.sv
// Bench for rgb_pwm: per-period low-cycle counts and pulse placement checked against a queue
// of expected on-times, pushed one period ahead of when they should appear on the pins.
module tb_rgb_pwm;

    localparam int PI = 1200;
    localparam int DW = $clog2(PI);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] pwm_value;
    logic [1:0]    state;
    logic          red_n, green_n, blue_n, period_start;

    rgb_pwm #(.PWM_INTERVAL(PI)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_value    (pwm_value),
        .state        (state),
        .red_n        (red_n),
        .green_n      (green_n),
        .blue_n       (blue_n),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        int         val;
        int         expR;
        int         expG;
        int         expB;
    } vec_t;

    typedef struct {
        int r;
        int g;
        int b;
    } exp_t;

    exp_t  sb[$];
    vec_t  vecs[14];
    string chName[3] = '{"red", "green", "blue"};
    int    testsRun = 0;
    int    testsFailed = 0;

    // Every comparison funnels through here so the summary counts stay honest.
    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Linear on-time to what the pins should show, including optional gamma shaping.
    function automatic int expOn(input int x);
`ifdef RGB_PWM_GAMMA_EN
        return (x * x) / PI;
`else
        return x;
`endif
    endfunction

    task automatic applyStimulus(input logic [1:0] st, input int val);
        state     = st;
        pwm_value = DW'(val);
    endtask

    // Starts on the negedge where period_start is high and ends on the next such negedge.
    task automatic runPeriod(input string tag, input logic [1:0] st, input int val,
                             input int changeAt, input logic [1:0] st2, input int val2,
                             input int nr, input int ng, input int nb);
        exp_t e;
        exp_t nxt;
        int   want[3];
        int   low[3];
        int   bad[3];
        int   pins[3];
        int   extraPs;
        if (sb.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
            e = '{0, 0, 0};
        end else begin
            e = sb.pop_front();
        end
        want = '{e.r, e.g, e.b};
        applyStimulus(st, val);
        nxt.r = expOn(nr);
        nxt.g = expOn(ng);
        nxt.b = expOn(nb);
        sb.push_back(nxt);
        low     = '{0, 0, 0};
        bad     = '{0, 0, 0};
        extraPs = 0;
        for (int i = 0; i < PI; i++) begin
            if (i == changeAt) applyStimulus(st2, val2);
            pins = '{int'(red_n), int'(green_n), int'(blue_n)};
            for (int c = 0; c < 3; c++) begin
                if (pins[c] == 0) low[c]++;
                if (pins[c] != ((i >= want[c]) ? 1 : 0)) bad[c]++;
            end
            if (i > 0 && period_start) extraPs++;
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("%s %s low cycles", tag, chName[c]), low[c], want[c]);
            checkOutput($sformatf("%s %s misplaced cycles", tag, chName[c]), bad[c], 0);
        end
        checkOutput($sformatf("%s stray period_start", tag), extraPs, 0);
        checkOutput($sformatf("%s period_start at wrap", tag), int'(period_start), 1);
    endtask

    task automatic waitPeriodStart(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < 8);
        checkOutput($sformatf("%s cycles to period_start", tag), k, 1);
    endtask

    initial begin
        // {state, pwm_value, expected red/green/blue on-time in the following period}
        vecs = '{
            '{2'd0,  300,  300,    0,    0},
            '{2'd0,  300,  300,    0,    0},
            '{2'd0,  600,  600,    0,    0},
            '{2'd0,  600,  600,    0,    0},
            '{2'd0,  600,  600,    0,    0},
            '{2'd1,  120,  600,  120,    0},
            '{2'd3,  900,  600,  120,    0},
            '{2'd2, 1500,  600,  120, 1200},
            '{2'd2,    0,  600,  120,    0},
            '{2'd0, 1500, 1200,  120,    0},
            '{2'd0, 1500, 1200,  120,    0},
            '{2'd0,    0,    0,  120,    0},
            '{2'd1, 2047,    0, 1200,    0},
            '{2'd3,    5,    0, 1200,    0}
        };

        rst_n = 1'b0;
        applyStimulus(2'd3, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset outputs cycle %0d", i),
                        int'({red_n, green_n, blue_n, period_start}), 14);
        end
        rst_n = 1'b1;
        sb.push_back('{0, 0, 0});
        waitPeriodStart("first release");

        foreach (vecs[i]) begin
            runPeriod($sformatf("vec %0d", i), vecs[i].st, vecs[i].val, -1, 2'd0, 0,
                      vecs[i].expR, vecs[i].expG, vecs[i].expB);
        end

        // Mid-period change keeps the current pulse and lands one period later.
        runPeriod("mid A1", 2'd0, 300, -1,  2'd0, 0,   300, 1200, 0);
        runPeriod("mid A2", 2'd0, 300, 499, 2'd0, 900, 900, 1200, 0);
        runPeriod("mid A3", 2'd0, 900, -1,  2'd0, 0,   900, 1200, 0);

        // A capture on the final edge misses the shadow load and appears two periods on.
        runPeriod("edge B1", 2'd0, 300, 1198, 2'd0, 900, 300, 1200, 0);
        runPeriod("edge B2", 2'd3, 0,   -1,   2'd0, 0,   900, 1200, 0);
        runPeriod("edge B3", 2'd3, 0,   -1,   2'd0, 0,   900, 1200, 0);

        // Reset asserted between clock edges while red is mid-pulse.
        for (int i = 0; i < 100; i++) @(negedge clk);
        checkOutput("red low before async reset", int'(red_n), 0);
        #2 rst_n = 1'b0;
        #1 checkOutput("outputs right after async reset",
                       int'({red_n, green_n, blue_n, period_start}), 14);
        sb.delete();
        for (int i = 0; i < 3; i++) @(negedge clk);
        checkOutput("outputs held in async reset",
                    int'({red_n, green_n, blue_n, period_start}), 14);
        rst_n = 1'b1;
        sb.push_back('{0, 0, 0});
        waitPeriodStart("second release");
        runPeriod("post reset P1", 2'd3, 0, -1, 2'd0, 0, 0, 0, 0);
        runPeriod("post reset P2", 2'd3, 0, -1, 2'd0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/rgb_pwm.md
# rgb_pwm

Downstream PWM stage for the fade generator. It consumes a duty value and a 0..2 channel index, and keeps one captured duty per RGB channel. It drives three active-low LED pins with glitch-free, period-aligned PWM. Each channel follows the incoming duty while selected and freezes its last value when deselected, which yields a colour-wheel sequence.

## Interface
- `PWM_INTERVAL`, default 1200: PWM period in clk cycles (100 µs at 12 MHz).
- `DUTY_W`, default `$clog2(PWM_INTERVAL)`: input duty width (must match the fade stage's `pwm_value` width).
- `clk` input, 1: system clock, 12 MHz.
- `rst_n` input, 1: asynchronous, active-low reset.
- `pwm_value` input, `DUTY_W`: requested duty in clk cycles per period.
- `state` input, 2: channel select; 0 = red, 1 = green, 2 = blue, 3 = no channel.
- `red_n` output, 1: red LED drive, registered, active-low.
- `green_n` output, 1: green LED drive, registered, active-low.
- `blue_n` output, 1: blue LED drive, registered, active-low.
- `period_start` output, 1: one-cycle pulse aligned with the first output cycle of each period.

## Operation
- **Period counter `cnt`**
  - Range 0..`PWM_INTERVAL`-1.
  - Increments every cycle and wraps to 0 after `PWM_INTERVAL`-1.
- **Capture registers `cap_r`, `cap_g`, `cap_b`**
  - Width `$clog2(PWM_INTERVAL+1)`.
  - Every cycle, the channel selected by `state` loads the clamped `pwm_value`; the other two hold.
  - `state`=3 updates nothing.
- **Clamp:** values greater than `PWM_INTERVAL` are stored as `PWM_INTERVAL`.
- **Active registers `act_r`, `act_g`, `act_b` (shadow load)**
  - Load from the capture path only on the edge where `cnt` = `PWM_INTERVAL`-1.
  - The load uses the pre-edge capture value. A capture on that same edge takes effect one period later.
- **Compare:** channel is on (pin driven 0) when `cnt` < act; otherwise the pin is 1.
  - act = 0: pin never low.
  - act = `PWM_INTERVAL`: pin low for the entire period.
- **Reset values**
  - Asserting `rst_n` low clears `cnt` and all `cap`/`act` registers to 0.
  - It drives `red_n`, `green_n` and `blue_n` to 1 and `period_start` to 0.
  - All of this is immediate, with no clock required, including mid-period.

## Timing
- Outputs are registered, so compare results appear one cycle after the `cnt` value that produced them.
- `period_start` is high in the cycle in which the outputs for `cnt`=0 are visible.
- **After reset release**
  - The first rising edge registers `cnt`=0, so `period_start`=1 in the following cycle.
  - The first period is fully dark because the act registers are 0.
- **Input-to-output latency**
  - A duty captured during period N drives the pins during period N+1.
  - Exception: a capture on the final edge of period N drives the pins during period N+2.
- A `state` or `pwm_value` change mid-period never alters the current period's pulse width (glitch-free requirement).
- The pulse is left-aligned: low for act cycles starting at `period_start`, then high for the rest of the period.

## Configuration
- `RGB_PWM_GAMMA_EN` defined:
  - Each act load uses `(cap*cap)/PWM_INTERVAL`, truncated and computed combinationally from cap.
  - No added latency.
  - Examples: 600→300, 1200→1200, 1→0, 34→0, 35→1.
- `RGB_PWM_GAMMA_EN` undefined:
  - act loads cap unchanged.
  - No multiplier or divider is synthesized.

## Test plan
- **Reset:** hold `rst_n`=0 for 10 cycles.
  - During reset: all `*_n`=1 and `period_start`=0.
  - After release: `period_start` pulses every 1200 cycles, and the first period has all pins at 1.
- **Single channel:** `state`=0, `pwm_value`=300 held.
  - From the second period on, `red_n` is low for exactly 300 of 1200 cycles starting at `period_start`.
  - `green_n` and `blue_n` stay 1.
- **Freeze and select:** `state`=0 with 600 for 3 periods, then `state`=1 with 120.
  - `red_n` stays low for 600 per period.
  - `green_n` goes low for 120 starting the period after the switch.
  - Applying `state`=3 with 900 changes nothing.
- **Mid-period change:** change `pwm_value` from 300 to 900 at `cnt`=500.
  - The current period keeps 300; the next period has 900.
  - A change applied exactly on the `cnt`=1199 edge shows up two periods later.
- **Clamp and bounds:** `pwm_value`=1500 gives `red_n` continuously low across the period boundary. `pwm_value`=0 gives `red_n` continuously 1.
- **Async reset and gamma:** pulse `rst_n` low at `cnt`=100 while `red_n`=0; `red_n` must go 1 without a clock edge. With `RGB_PWM_GAMMA_EN` defined, `pwm_value`=600 gives 300 low cycles per period.
